// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_controller
//  Description : Multicycle control FSM for a 3-bit-opcode MIPS-subset datapath
//                with a memory-ready handshake and a timeout watchdog.
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] i_op,
    input  logic [3:0] i_funct,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output logic       o_mem_req,
    output logic       o_memwrite,
    output logic       o_iord,
    output logic       o_irwrite,
    output logic       o_pcen,
    output logic [1:0] o_pcsrc,
    output logic       o_alusrca,
    output logic [1:0] o_alusrcb,
    output logic [2:0] o_alucontrol,
    output logic       o_regdst,
    output logic       o_memtoreg,
    output logic       o_regwrite,
    output logic       o_illegal_op,
    output logic       o_bus_error,
    output logic [3:0] o_state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_RTWB   = 4'd7,
        S_BEQEX  = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JEX    = 4'd11
    } state_t;

    localparam logic [2:0]       c_ALU_ADD = 3'b010;
    localparam logic [2:0]       c_ALU_SUB = 3'b110;
    localparam logic [2:0]       c_ALU_AND = 3'b000;
    localparam logic [2:0]       c_ALU_OR  = 3'b001;
    localparam logic [2:0]       c_ALU_SLT = 3'b111;
    localparam bit               c_TO_EN   = (MEM_TIMEOUT > 0);
    localparam logic [CNT_W-1:0] c_LIMIT   = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_illegal;
    logic             r_bus_err;
    logic             w_mem_req;
    logic             w_memwrite;
    logic             w_irwrite;
    logic             w_pcen;
    logic             w_regwrite;
    logic             w_set_ill;
    logic             w_wait;
    logic             w_timeout;

    // Timeout fires on the wait cycle that would bring the counter to MEM_TIMEOUT.
    assign w_wait    = w_mem_req & ~i_mem_ready;
    assign w_timeout = c_TO_EN & w_wait & (r_cnt == c_LIMIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_FETCH;
            r_cnt     <= '0;
            r_illegal <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            r_state   <= w_timeout ? S_FETCH : w_next;
            r_cnt     <= (w_wait && !w_timeout) ? r_cnt + CNT_W'(1) : '0;
            r_illegal <= r_illegal | w_set_ill;
            r_bus_err <= r_bus_err | w_timeout;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_mem_req    = 1'b0;
        w_memwrite   = 1'b0;
        w_irwrite    = 1'b0;
        w_pcen       = 1'b0;
        w_regwrite   = 1'b0;
        w_set_ill    = 1'b0;
        o_iord       = 1'b0;
        o_pcsrc      = 2'b00;
        o_alusrca    = 1'b0;
        o_alusrcb    = 2'b00;
        o_alucontrol = c_ALU_ADD;
        o_regdst     = 1'b0;
        o_memtoreg   = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                o_alusrcb = 2'b01;
                if (i_mem_ready) begin
                    w_irwrite = 1'b1;
                    w_pcen    = 1'b1;
                    w_next    = S_DECODE;
                end
            end
            S_DECODE: begin
                // ALU precomputes the branch target while the opcode is decoded.
                o_alusrcb = 2'b11;
                case (i_op)
                    3'b000:         w_next = S_RTEX;
                    3'b001, 3'b010: w_next = S_MEMADR;
                    3'b011:         w_next = S_BEQEX;
                    3'b100:         w_next = S_ADDIEX;
                    3'b101:         w_next = S_JEX;
                    default: begin
                        w_set_ill = 1'b1;
                        w_next    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                o_alusrca = 1'b1;
                o_alusrcb = 2'b10;
                w_next    = (i_op == 3'b001) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_mem_req = 1'b1;
                o_iord    = 1'b1;
                if (i_mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                o_memtoreg = 1'b1;
                w_regwrite = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWR: begin
                w_mem_req  = 1'b1;
                w_memwrite = 1'b1;
                o_iord     = 1'b1;
                if (i_mem_ready) w_next = S_FETCH;
            end
            S_RTEX: begin
                o_alusrca = 1'b1;
                case (i_funct)
                    4'd1:    o_alucontrol = c_ALU_SUB;
                    4'd2:    o_alucontrol = c_ALU_AND;
                    4'd3:    o_alucontrol = c_ALU_OR;
                    4'd4:    o_alucontrol = c_ALU_SLT;
                    default: o_alucontrol = c_ALU_ADD;
                endcase
                w_next = S_RTWB;
            end
            S_RTWB: begin
                o_regdst   = 1'b1;
                w_regwrite = 1'b1;
                w_next     = S_FETCH;
            end
            S_BEQEX: begin
                o_alusrca    = 1'b1;
                o_alucontrol = c_ALU_SUB;
                o_pcsrc      = 2'b01;
                w_pcen       = i_zero;
                w_next       = S_FETCH;
            end
            S_ADDIEX: begin
                o_alusrca = 1'b1;
                o_alusrcb = 2'b10;
                w_next    = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_regwrite = 1'b1;
                w_next     = S_FETCH;
            end
            S_JEX: begin
                o_pcsrc = 2'b10;
                w_pcen  = 1'b1;
                w_next  = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Strobes are gated by reset so they drop the instant reset asserts.
    assign o_mem_req    = w_mem_req  & reset;
    assign o_memwrite   = w_memwrite & reset;
    assign o_irwrite    = w_irwrite  & reset;
    assign o_pcen       = w_pcen     & reset;
    assign o_regwrite   = w_regwrite & reset;
    assign o_illegal_op = r_illegal;
    assign o_bus_error  = r_bus_err;
    assign o_state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// Self-checking bench for multicycle_controller: instruction-level model of the
// expected state trace, control word and sticky flags under random handshakes.
module tb_multicycle_controller;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] op = '0;
    logic [3:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic       mem_req, memwrite, iord, irwrite, pcen, alusrca, regdst, memtoreg, regwrite;
    logic       illegal_op, bus_error;
    logic [1:0] pcsrc, alusrcb;
    logic [2:0] alucontrol;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;
    bit m_ill = 1'b0;
    bit m_bus = 1'b0;

    multicycle_controller #(.MEM_TIMEOUT(TO), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .i_op(op), .i_funct(funct), .i_zero(zero),
        .i_mem_ready(mem_ready), .o_mem_req(mem_req), .o_memwrite(memwrite),
        .o_iord(iord), .o_irwrite(irwrite), .o_pcen(pcen), .o_pcsrc(pcsrc),
        .o_alusrca(alusrca), .o_alusrcb(alusrcb), .o_alucontrol(alucontrol),
        .o_regdst(regdst), .o_memtoreg(memtoreg), .o_regwrite(regwrite),
        .o_illegal_op(illegal_op), .o_bus_error(bus_error), .o_state(state)
    );

    always #5 clk = ~clk;

    wire logic [15:0] obs_vec = {mem_req, memwrite, iord, irwrite, pcen, pcsrc, alusrca,
                                 alusrcb, alucontrol, regdst, memtoreg, regwrite};

    function automatic logic [2:0] alu_of(input logic [3:0] f);
        logic [2:0] tbl [5];
        tbl = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
        return (f < 4'd5) ? tbl[int'(f)] : 3'b010;
    endfunction

    // Required control word for a phase of an instruction.
    function automatic logic [15:0] exp_vec(input int s, input bit r, input bit z,
                                            input logic [3:0] f, input bit in_rst);
        logic mreq, mw, ird, irw, pce, asa, rd, m2r, rw;
        logic [1:0] pcs, asb;
        logic [2:0] alu;
        {mreq, mw, ird, irw, pce, asa, rd, m2r, rw} = '0;
        pcs = 2'b00; asb = 2'b00; alu = 3'b010;
        case (s)
            0:  begin mreq = 1; asb = 2'b01; irw = r; pce = r; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mreq = 1; ird = 1; end
            4:  begin m2r = 1; rw = 1; end
            5:  begin mreq = 1; mw = 1; ird = 1; end
            6:  begin asa = 1; alu = alu_of(f); end
            7:  begin rd = 1; rw = 1; end
            8:  begin asa = 1; alu = 3'b110; pcs = 2'b01; pce = z; end
            9:  begin asa = 1; asb = 2'b10; end
            10: rw = 1;
            11: begin pcs = 2'b10; pce = 1; end
            default: ;
        endcase
        if (in_rst) {mreq, mw, irw, pce, rw} = '0;
        return {mreq, mw, ird, irw, pce, pcs, asa, asb, alu, rd, m2r, rw};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Called at posedge+1: drive, check mid-cycle, advance to next posedge+1.
    task automatic cycle(input int s, input bit r);
        mem_ready = r;
        #2;
        chk("state", {12'd0, state}, 16'(s));
        chk("ctrl", obs_vec, exp_vec(s, r, zero, funct, 1'b0));
        chk("flags", {14'd0, illegal_op, bus_error}, {14'd0, m_ill, m_bus});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        chk("rst_state", {12'd0, state}, 16'd0);
        chk("rst_ctrl", obs_vec, exp_vec(0, mem_ready, zero, funct, 1'b1));
        chk("rst_flags", {14'd0, illegal_op, bus_error}, 16'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        m_ill = 1'b0;
        m_bus = 1'b0;
    endtask

    function automatic int rand_wait();
        return ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 2)) : int'($urandom_range(3, 6));
    endfunction

    // wf/wm: not-ready cycles in FETCH / data access (-1 = random).
    task automatic run_instr(input logic [2:0] o, input logic [3:0] f, input bit z,
                             input int wf, input int wm);
        int ph[$];
        int w;
        op = o; funct = f; zero = z;
        case (o)
            3'd0:    ph = '{0, 1, 6, 7};
            3'd1:    ph = '{0, 1, 2, 3, 4};
            3'd2:    ph = '{0, 1, 2, 5};
            3'd3:    ph = '{0, 1, 8};
            3'd4:    ph = '{0, 1, 9, 10};
            3'd5:    ph = '{0, 1, 11};
            default: ph = '{0, 1};
        endcase
        foreach (ph[k]) begin
            if (ph[k] == 0 || ph[k] == 3 || ph[k] == 5) begin
                w = (ph[k] == 0) ? wf : wm;
                if (w < 0) w = rand_wait();
                for (int j = 0; j < w; j++) begin
                    cycle(ph[k], 1'b0);
                    if (j == TO - 1) begin
                        m_bus = 1'b1;
                        return;
                    end
                end
                cycle(ph[k], 1'b1);
            end else begin
                cycle(ph[k], 1'($urandom % 2));
                if (ph[k] == 1 && o > 3'd5) m_ill = 1'b1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        do_reset();

        run_instr(3'b000, 4'd0, 1'b0, 0, 0);   // R add
        run_instr(3'b000, 4'd1, 1'b0, 1, 0);   // R sub
        run_instr(3'b000, 4'd4, 1'b0, 0, 0);   // R slt
        run_instr(3'b000, 4'd9, 1'b0, 0, 0);   // unknown funct -> add
        run_instr(3'b001, 4'd0, 1'b0, 0, 3);   // LW, 3 waits in MEMRD
        run_instr(3'b010, 4'd0, 1'b0, 2, 2);   // SW
        run_instr(3'b011, 4'd0, 1'b1, 0, 0);   // BEQ taken
        run_instr(3'b011, 4'd0, 1'b0, 0, 0);   // BEQ not taken
        run_instr(3'b100, 4'd0, 1'b0, 0, 0);   // ADDI
        run_instr(3'b101, 4'd0, 1'b0, 0, 0);   // J
        run_instr(3'b111, 4'd0, 1'b0, 0, 0);   // illegal
        run_instr(3'b000, 4'd0, 1'b0, 0, 0);   // illegal_op stays set
        run_instr(3'b000, 4'd0, 1'b0, TO, 0);  // FETCH timeout
        run_instr(3'b010, 4'd0, 1'b0, 0, TO);  // MEMWR timeout
        run_instr(3'b100, 4'd0, 1'b0, 0, 0);

        // Asynchronous reset in the middle of a MEMWR wait.
        op = 3'b010; zero = 1'b0;
        cycle(0, 1'b1);
        cycle(1, 1'b0);
        cycle(2, 1'b0);
        cycle(5, 1'b0);
        mem_ready = 1'b0;
        #2;
        chk("pre_rst_wr", {14'd0, mem_req, memwrite}, 16'd3);
        reset = 1'b0;
        #1;
        chk("async_drop", {14'd0, mem_req, memwrite}, 16'd0);
        chk("async_state", {12'd0, state}, 16'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        m_ill = 1'b0;
        m_bus = 1'b0;
        run_instr(3'b101, 4'd0, 1'b0, 0, 0);

        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 19) == 0) do_reset();
            run_instr(3'($urandom_range(0, 7)), 4'($urandom), 1'($urandom), -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
